wl_dsp48_sched: RTL and testbench

Round-robin scheduler that shares one pre-adder DSP48 multiplier IP (P = (A+D)*B, 18-bit operands, 36-bit product, fixed pipeline latency) among NREQ requesters in the canny pipeline. It grants one operand triple per cycle and tags each issued operation with its requester index. It re-associates each product with its tag at the DSP output, and owns the IP's SCLR sequencing after reset and on flush.

---
 rtl/wl_dsp48_sched_pkg.sv | 26 ++
 rtl/wl_rr_arbiter.sv | 36 +++
 rtl/wl_dsp48_sched.sv | 138 +++++++++++++
 tb/tb_wl_dsp48_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wl_dsp48_sched_pkg.sv
// Shared definitions for the DSP48 request scheduler.
// Holds the state encoding, a constant clog2 helper and the default IP geometry.
package wl_dsp48_sched_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Operand, product and latency defaults matching the DSP IP wrapper.
    localparam int DEF_DW  = 18;
    localparam int DEF_PW  = 36;
    localparam int DEF_LAT = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wl_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after ptr, with wrap.
// The pointer register is owned by the parent.
module wl_rr_arbiter
    import wl_dsp48_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            found
);

    int cand;

    // NOTE: every output gets a default before the scan so no path leaves a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && valid[cand]) begin
                found     = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wl_dsp48_sched.sv
// Shares one (A+D)*B DSP48 among NREQ requesters, tagging each op with its requester
// so the product can be re-associated at the IP output; also sequences the IP SCLR.
module wl_dsp48_sched
    import wl_dsp48_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int DW   = DEF_DW,
    parameter  int PW   = DEF_PW,
    parameter  int LAT  = DEF_LAT,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_d,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 dsp_sclr,
    output logic [DW-1:0]        dsp_a,
    output logic [DW-1:0]        dsp_d,
    output logic [DW-1:0]        dsp_b,
    input  logic [PW-1:0]        dsp_p,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [PW-1:0]        res_p,
    output logic                 busy
);

    localparam int CW = clog2(LAT + 1);

    state_t          state, state_next;
    logic [CW-1:0]   init_cnt, init_cnt_next;
    logic            sclr_next;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic            accept;
    logic            transfer;
    logic [LAT:0]    tag_valid;
    logic [IDW-1:0]  tag_id [LAT+1];

    wl_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (grant_found)
    );

    assign accept    = (state == ST_RUN) && !flush;
    assign transfer  = accept && grant_found;
    assign req_ready = accept ? grant : '0;
    assign busy      = |tag_valid;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            dsp_sclr <= 1'b1;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
            dsp_sclr <= sclr_next;
        end
    end

    // SCLR stays high for LAT+1 cycles after reset so the IP pipeline is fully cleared.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        sclr_next     = 1'b0;
        case (state)
            ST_INIT: begin
                sclr_next = 1'b1;
                if (init_cnt == CW'(LAT)) begin
                    state_next = ST_RUN;
                    sclr_next  = 1'b0;
                end else begin
                    init_cnt_next = init_cnt + 1'b1;
                end
            end
            ST_RUN:  sclr_next = 1'b0;
            default: state_next = ST_INIT;
        endcase
        if (flush) begin
            sclr_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_a <= '0;
            dsp_d <= '0;
            dsp_b <= '0;
            ptr   <= '0;
        end else if (transfer) begin
            dsp_a <= req_a[grant_idx*DW +: DW];
            dsp_d <= req_d[grant_idx*DW +: DW];
            dsp_b <= req_b[grant_idx*DW +: DW];
            ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
            dsp_a <= '0;
            dsp_d <= '0;
            dsp_b <= '0;
        end
    end

    // Tag pipe: stage LAT lines up with the product appearing on dsp_p.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_p     <= '0;
        end else begin
            tag_valid <= flush ? '0 : {tag_valid[LAT-1:0], transfer};
            res_valid <= tag_valid[LAT] && !flush;
            if (tag_valid[LAT] && !flush) begin
                res_id <= tag_id[LAT];
                res_p  <= dsp_p;
            end
        end
    end

    // NOTE: tag ids carry no reset; they are only consumed when the matching valid is set.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_idx;
        for (int k = 1; k <= LAT; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
    end

endmodule

// File: tb/tb_wl_dsp48_sched.sv
// Bench for wl_dsp48_sched: a behavioural DSP IP plus an issue-order scoreboard
// predicting grants, result timing, ids, products, busy and SCLR.
module tb_wl_dsp48_sched;

    localparam int NREQ = 4;
    localparam int DW   = 18;
    localparam int PW   = 36;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    typedef struct {
        int              due;
        int              id;
        longint unsigned p;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ*DW-1:0] req_d = '0;
    logic [NREQ*DW-1:0] req_b = '0;
    logic [NREQ-1:0]    req_ready;
    logic               dsp_sclr;
    logic [DW-1:0]      dsp_a, dsp_d, dsp_b;
    logic [PW-1:0]      dsp_p;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [PW-1:0]      res_p;
    logic               busy;

    int checks_total  = 0;
    int checks_passed = 0;

    int              cyc;
    int              ptr_m;
    bit              flush_last;
    int              sclr_hi;
    exp_t            exp_q[$];
    logic [NREQ-1:0] grants[$];
    logic [IDW-1:0]  res_ids[$];
    logic [PW-1:0]   res_ps[$];

    always #5 clk = ~clk;

    wl_dsp48_sched #(.NREQ(NREQ), .DW(DW), .PW(PW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_d     (req_d),
        .req_b     (req_b),
        .req_ready (req_ready),
        .dsp_sclr  (dsp_sclr),
        .dsp_a     (dsp_a),
        .dsp_d     (dsp_d),
        .dsp_b     (dsp_b),
        .dsp_p     (dsp_p),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    // Behavioural DSP IP: P = (A+D)*B, LAT edges from operands to output, SCLR clears.
    logic [PW-1:0] ip_pipe [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst || dsp_sclr) begin
            for (int k = 0; k < LAT; k++) ip_pipe[k] <= '0;
        end else begin
            ip_pipe[0] <= PW'((64'(dsp_a) + 64'(dsp_d)) * 64'(dsp_b));
            for (int k = 1; k < LAT; k++) ip_pipe[k] <= ip_pipe[k-1];
        end
    end
    assign dsp_p = ip_pipe[LAT-1];

    function automatic longint unsigned prod(input logic [DW-1:0] a, d, b);
        longint unsigned s;
        s = (64'(a) + 64'(d)) * 64'(b);
        return s & ((64'd1 << PW) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_op(input int i, input int a, input int d, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_d[i*DW +: DW] = DW'(d);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_dsp_sclr",  64'(dsp_sclr),  64'(1));
        check("rst_dsp_a",     64'(dsp_a),     64'(0));
        check("rst_dsp_d",     64'(dsp_d),     64'(0));
        check("rst_dsp_b",     64'(dsp_b),     64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_id",    64'(res_id),    64'(0));
        check("rst_res_p",     64'(res_p),     64'(0));
        check("rst_busy",      64'(busy),      64'(0));
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        repeat (n) begin
            @(negedge clk);
            check_reset_values();
        end
        rst        = 1'b0;
        cyc        = 0;
        ptr_m      = 0;
        flush_last = 1'b0;
        exp_q.delete();
        #1;
        check("release_sclr", 64'(dsp_sclr), 64'(1));
        sclr_hi = dsp_sclr ? 1 : 0;
    endtask

    // One cycle: predict the grant, cross the edge, then check results against the scoreboard.
    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_ready;
        exp_t            e;
        #1;
        g = -1;
        if (cyc >= LAT + 1 && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (ptr_m + k) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (req_ready != '0) grants.push_back(req_ready);
        e.due = 0;
        e.id  = 0;
        e.p   = 0;
        if (g >= 0) begin
            e.due = cyc + 1 + LAT + 1;
            e.id  = g;
            e.p   = prod(req_a[g*DW +: DW], req_d[g*DW +: DW], req_b[g*DW +: DW]);
        end
        @(posedge clk);
        cyc++;
        flush_last = flush;
        if (flush) begin
            exp_q.delete();
        end else if (g >= 0) begin
            exp_q.push_back(e);
            ptr_m = (g + 1) % NREQ;
        end
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("res_valid", 64'(res_valid), 64'(1));
            check("res_id",    64'(res_id),    64'(exp_q[0].id));
            check("res_p",     64'(res_p),     64'(exp_q[0].p));
            void'(exp_q.pop_front());
        end else begin
            check("res_valid_idle", 64'(res_valid), 64'(0));
        end
        check("busy", 64'(busy), 64'(exp_q.size() != 0));
        check("dsp_sclr", 64'(dsp_sclr), 64'((cyc < LAT + 1) || flush_last));
        if (res_valid) begin
            res_ids.push_back(res_id);
            res_ps.push_back(res_p);
        end
        if (dsp_sclr) sclr_hi++;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    initial begin
        int rr_p[4];
        rr_p = '{264, 63, 2540, 360};

        set_op(0, 10, 34, 6);
        set_op(1, 5, 4, 7);
        set_op(2, 127, 127, 10);
        set_op(3, 24, 21, 8);

        // Reset release: SCLR for LAT+1 cycles, first grant on the first run cycle.
        do_reset(5);
        grants.delete();
        req_valid = 4'b0001;
        repeat (5) step();
        check("init_sclr_cycles", 64'(sclr_hi), 64'(LAT + 1));
        check("init_grant_count", 64'(grants.size()), 64'(1));
        check("init_first_grant", 64'(grants[0]), 64'(4'b0001));
        idle(6);

        // Single op from requester 2.
        set_op(2, 14, 90, 5);
        res_ids.delete();
        res_ps.delete();
        req_valid = 4'b0100;
        step();
        idle(6);
        set_op(2, 127, 127, 10);
        check("single_count", 64'(res_ids.size()), 64'(1));
        check("single_id",    64'(res_ids[0]),     64'(2));
        check("single_p",     64'(res_ps[0]),      64'(520));

        // Fairness and wrap: pointer sits at 3.
        grants.delete();
        req_valid = 4'b1001;
        repeat (3) step();
        idle(6);
        check("wrap_grant0", 64'(grants[0]), 64'(4'b1000));
        check("wrap_grant1", 64'(grants[1]), 64'(4'b0001));
        check("wrap_grant2", 64'(grants[2]), 64'(4'b1000));

        // Round-robin with all requesters valid.
        grants.delete();
        res_ids.delete();
        res_ps.delete();
        req_valid = 4'b1111;
        repeat (4) step();
        idle(6);
        check("rr_count", 64'(res_ids.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("rr_grant", 64'(grants[i]),  64'(NREQ'(1) << i));
            check("rr_id",    64'(res_ids[i]), 64'(i));
            check("rr_p",     64'(res_ps[i]),  64'(rr_p[i]));
        end

        // Flush one cycle after three back-to-back issues.
        req_valid = 4'b1111;
        repeat (3) step();
        res_ids.delete();
        res_ps.delete();
        sclr_hi = 0;
        flush   = 1'b1;
        step();
        check("flush_busy", 64'(busy), 64'(0));
        flush = 1'b0;
        idle(6);
        check("flush_no_result", 64'(res_ids.size()), 64'(0));
        check("flush_sclr_once", 64'(sclr_hi), 64'(1));
        req_valid = 4'b0001;
        step();
        idle(6);
        check("post_flush_count", 64'(res_ids.size()), 64'(1));
        check("post_flush_id",    64'(res_ids[0]),     64'(0));
        check("post_flush_p",     64'(res_ps[0]),      64'(264));

        // Asynchronous reset between edges with two ops in flight.
        req_valid = 4'b1111;
        repeat (2) step();
        req_valid = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values();
        do_reset(3);
        res_ids.delete();
        idle(12);
        check("no_stale_result", 64'(res_ids.size()), 64'(0));

        // Randomised traffic with occasional flush.
        repeat (300) begin
            req_valid = NREQ'($urandom);
            flush     = ($urandom_range(15) == 0);
            for (int i = 0; i < NREQ; i++) begin
                set_op(i, int'($urandom_range(0, (1 << DW) - 1)),
                          int'($urandom_range(0, (1 << DW) - 1)),
                          int'($urandom_range(0, (1 << DW) - 1)));
            end
            step();
        end
        flush = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
